// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared encodings for the micro-sequencer slice.
//   OP_*  : 3-bit sequencing operations carried by each microinstruction
//   CC_*  : 4-bit branch condition selects evaluated by micro_cond_eval
//   F*    : bit positions of the latched ALU flags inside the {z,n,c,w} vector
package micro_seq_pkg;

   localparam logic [2:0] OP_NEXT  = 3'd0;
   localparam logic [2:0] OP_JUMP  = 3'd1;
   localparam logic [2:0] OP_BCOND = 3'd2;
   localparam logic [2:0] OP_CALL  = 3'd3;
   localparam logic [2:0] OP_RET   = 3'd4;
   localparam logic [2:0] OP_HALT  = 3'd5;

   localparam logic [3:0] CC_ALWAYS = 4'd0;
   localparam logic [3:0] CC_Z      = 4'd1;
   localparam logic [3:0] CC_NZ     = 4'd2;
   localparam logic [3:0] CC_N      = 4'd3;
   localparam logic [3:0] CC_NN     = 4'd4;
   localparam logic [3:0] CC_C      = 4'd5;
   localparam logic [3:0] CC_NC     = 4'd6;
   localparam logic [3:0] CC_W      = 4'd7;
   localparam logic [3:0] CC_NW     = 4'd8;
   localparam logic [3:0] CC_SLT    = 4'd9;
   localparam logic [3:0] CC_SGE    = 4'd10;
   localparam logic [3:0] CC_ULT    = 4'd11;
   localparam logic [3:0] CC_UGE    = 4'd12;
   localparam logic [3:0] CC_SLE    = 4'd13;
   localparam logic [3:0] CC_SGT    = 4'd14;
   localparam logic [3:0] CC_NEVER  = 4'd15;

   localparam int unsigned FZ = 3;
   localparam int unsigned FN = 2;
   localparam int unsigned FC = 1;
   localparam int unsigned FW = 0;

endpackage

// File: rtl/micro_cond_eval.sv
// micro_cond_eval: combinational branch-condition evaluator.
//   flags : latched {z,n,c,w}
//   cond  : condition select (CC_* encodings)
//   true  : 1 when the selected condition holds
module micro_cond_eval
   import micro_seq_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       true
);

   logic z, n, c, w, lt;

   assign z  = flags[FZ];
   assign n  = flags[FN];
   assign c  = flags[FC];
   assign w  = flags[FW];
   // signed less-than: sign of the result corrected by overflow
   assign lt = n ^ w;

   always_comb begin
      true = 1'b0;
      case (cond)
         CC_ALWAYS: true = 1'b1;
         CC_Z:      true = z;
         CC_NZ:     true = ~z;
         CC_N:      true = n;
         CC_NN:     true = ~n;
         CC_C:      true = c;
         CC_NC:     true = ~c;
         CC_W:      true = w;
         CC_NW:     true = ~w;
         CC_SLT:    true = lt;
         CC_SGE:    true = ~lt;
         CC_ULT:    true = ~c;
         CC_UGE:    true = c;
         CC_SLE:    true = z | lt;
         CC_SGT:    true = ~z & ~lt;
         CC_NEVER:  true = 1'b0;
         default:   true = 1'b0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram counter with flag register, conditional
// branching and a small return stack.
//   clock, reset_n          : rising-edge clock, async active-low reset
//   z_in/n_in/c_in/w_in     : ALU flags, latched when flag_we=1 and not stalled
//   op, cond, target        : current microinstruction sequencing fields
//   stall                   : freezes upc/stack/taken and flag loading
//   upc                     : current micro-address
//   flags                   : latched {z,n,c,w}
//   taken                   : 1 in the cycle after a redirect
//   halted, err             : sticky halt and stack over/underflow
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int unsigned UAW    = 8,
   parameter int unsigned SDEPTH = 4
)
(
   input  logic           clock,
   input  logic           reset_n,
   input  logic           z_in,
   input  logic           n_in,
   input  logic           c_in,
   input  logic           w_in,
   input  logic           flag_we,
   input  logic [2:0]     op,
   input  logic [3:0]     cond,
   input  logic [UAW-1:0] target,
   input  logic           stall,
   output logic [UAW-1:0] upc,
   output logic [3:0]     flags,
   output logic           taken,
   output logic           halted,
   output logic           err
);

   // sp runs 0..SDEPTH, so it needs one bit more than the stack index
   localparam int unsigned IW  = $clog2(SDEPTH);
   localparam int unsigned SPW = IW + 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

   logic [UAW-1:0] stack_mem [SDEPTH];
   logic [SPW-1:0] sp, sp_inc, sp_dec, sp_next;
   logic [UAW-1:0] upc_inc, upc_next;
   logic           cond_true, advance, push, halt_req, err_set, taken_next;

   micro_cond_eval u_cond (
      .flags (flags),
      .cond  (cond),
      .true  (cond_true)
   );

   assign upc_inc = upc + UAW'(1);
   assign sp_inc  = sp + SPW'(1);
   assign sp_dec  = sp - SPW'(1);
   assign advance = ~stall & ~halted;

   always_comb begin
      upc_next   = upc_inc;
      sp_next    = sp;
      taken_next = 1'b0;
      push       = 1'b0;
      halt_req   = 1'b0;
      err_set    = 1'b0;
      case (op)
         OP_JUMP: begin
            upc_next   = target;
            taken_next = 1'b1;
         end
         OP_BCOND: begin
            if (cond_true) begin
               upc_next   = target;
               taken_next = 1'b1;
            end
         end
         OP_CALL: begin
            // a full stack degrades the call to NEXT and flags the error
            if (sp == SP_FULL) begin
               err_set = 1'b1;
            end else begin
               push       = 1'b1;
               sp_next    = sp_inc;
               upc_next   = target;
               taken_next = 1'b1;
            end
         end
         OP_RET: begin
            if (sp == '0) begin
               err_set = 1'b1;
            end else begin
               sp_next    = sp_dec;
               upc_next   = stack_mem[sp_dec[IW-1:0]];
               taken_next = 1'b1;
            end
         end
         OP_HALT: begin
            upc_next = upc;
            halt_req = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         upc    <= '0;
         flags  <= '0;
         sp     <= '0;
         taken  <= 1'b0;
         halted <= 1'b0;
         err    <= 1'b0;
      end else begin
         // flags keep loading while halted; only stall blocks them
         if (!stall && flag_we) begin
            flags[FZ] <= z_in;
            flags[FN] <= n_in;
            flags[FC] <= c_in;
            flags[FW] <= w_in;
         end
         if (advance) begin
            upc   <= upc_next;
            sp    <= sp_next;
            taken <= taken_next;
            if (halt_req) halted <= 1'b1;
            if (err_set)  err    <= 1'b1;
         end
      end
   end

   // stack contents need no reset; sp alone defines what is valid
   always_ff @(posedge clock) begin
      if (advance && push) stack_mem[sp[IW-1:0]] <= upc_inc;
   end

endmodule
